// File: rtl/autoconfig_pkg.sv
// Shared definitions for the Zorro II AutoConfig chain: size codes, register
// indices, chain states and the size-code to 64K-block-count helper.
package autoconfig_pkg;

  localparam logic [2:0] SZ_8M   = 3'd0;
  localparam logic [2:0] SZ_64K  = 3'd1;
  localparam logic [2:0] SZ_128K = 3'd2;
  localparam logic [2:0] SZ_256K = 3'd3;
  localparam logic [2:0] SZ_512K = 3'd4;
  localparam logic [2:0] SZ_1M   = 3'd5;
  localparam logic [2:0] SZ_2M   = 3'd6;
  localparam logic [2:0] SZ_4M   = 3'd7;

  localparam logic [7:0] REG_TYPE      = 8'h00;
  localparam logic [7:0] REG_SIZE      = 8'h01;
  localparam logic [7:0] REG_PROD_HI   = 8'h02;
  localparam logic [7:0] REG_PROD_LO   = 8'h03;
  localparam logic [7:0] REG_FLAGS     = 8'h04;
  localparam logic [7:0] REG_RSVD      = 8'h05;
  localparam logic [7:0] REG_MFG_FIRST = 8'h08;
  localparam logic [7:0] REG_MFG_LAST  = 8'h0B;
  localparam logic [7:0] REG_SER_FIRST = 8'h0C;
  localparam logic [7:0] REG_SER_LAST  = 8'h13;
  localparam logic [7:0] REG_ROM_FIRST = 8'h14;
  localparam logic [7:0] REG_ROM_LAST  = 8'h17;
  localparam logic [7:0] REG_CTL_LO    = 8'h20;
  localparam logic [7:0] REG_CTL_HI    = 8'h21;
  localparam logic [7:0] REG_BASE_HI   = 8'h24;
  localparam logic [7:0] REG_BASE_LO   = 8'h25;
  localparam logic [7:0] REG_SHUTUP    = 8'h26;

  // Encoding of the Zorro II bus state machine's data phase.
  localparam logic [2:0] Z2_ST_DATA = 3'd3;

  typedef enum logic [1:0] {
    CH_INIT   = 2'd0,
    CH_ACTIVE = 2'd1,
    CH_DONE   = 2'd2
  } chain_state_t;

  // Number of 64K blocks (A23..A16 steps) covered by a size code.
  function automatic logic [8:0] blocks(input logic [2:0] code);
    case (code)
      SZ_8M:   blocks = 9'd128;
      SZ_64K:  blocks = 9'd1;
      SZ_128K: blocks = 9'd2;
      SZ_256K: blocks = 9'd4;
      SZ_512K: blocks = 9'd8;
      SZ_1M:   blocks = 9'd16;
      SZ_2M:   blocks = 9'd32;
      SZ_4M:   blocks = 9'd64;
      default: blocks = 9'd128;
    endcase
  endfunction

endpackage

// File: rtl/autoconfig_rom.sv
// Combinational AutoConfig register nibble lookup for one logical board.
module autoconfig_rom
  import autoconfig_pkg::*;
(
  input  logic [7:0]  index,
  input  logic        is_mem,
  input  logic        rom_vec,
  input  logic [2:0]  size,
  input  logic [7:0]  prod_id,
  input  logic [15:0] mfg_id,
  input  logic [31:0] serial,
  input  logic [15:0] rom_offset,
  output logic [3:0]  nibble
);

  logic [3:0] mfg_nib_s;
  logic [3:0] ser_nib_s;
  logic [3:0] rom_nib_s;
  logic [2:0] ser_pos_s;

  // Multi-nibble fields are presented most significant nibble first.
  assign mfg_nib_s = 4'(mfg_id >> {~index[1:0], 2'b00});
  assign ser_pos_s = 3'(index - REG_SER_FIRST);
  assign ser_nib_s = 4'(serial >> {~ser_pos_s, 2'b00});
  assign rom_nib_s = 4'(rom_offset >> {~index[1:0], 2'b00});

  // Register decode; unimplemented locations read as all ones.
  always_comb begin
    nibble = 4'hF;
    case (index) inside
      REG_TYPE:                     nibble = {2'b11, is_mem, rom_vec};
      REG_SIZE:                     nibble = {1'b0, size};
      REG_PROD_HI:                  nibble = ~prod_id[7:4];
      REG_PROD_LO:                  nibble = ~prod_id[3:0];
      REG_FLAGS:                    nibble = ~{is_mem, 3'b000};
      REG_RSVD:                     nibble = 4'hF;
      [REG_MFG_FIRST:REG_MFG_LAST]: nibble = ~mfg_nib_s;
      [REG_SER_FIRST:REG_SER_LAST]: nibble = ~ser_nib_s;
      [REG_ROM_FIRST:REG_ROM_LAST]: begin
        if (rom_vec) begin
          nibble = ~rom_nib_s;
        end else begin
          nibble = 4'hF;
        end
      end
      REG_CTL_LO, REG_CTL_HI:       nibble = 4'h0;
      default:                      nibble = 4'hF;
    endcase
  end

endmodule

// File: rtl/autoconfig_chain.sv
// Zorro II AutoConfig engine presenting up to four logical boards in turn,
// with CFGIN/CFGOUT chaining, latched base addresses and size-aware hit decode.
module autoconfig_chain
  import autoconfig_pkg::*;
#(
  parameter int                        NUM_BOARDS = 3,
  parameter logic [15:0]               MFG_ID     = 16'd2011,
  parameter logic [8*NUM_BOARDS-1:0]   PROD_IDS   = {8'd74, 8'h06, 8'h72},
  parameter logic [3*NUM_BOARDS-1:0]   SIZES      = {3'd1, 3'd2, 3'd0},
  parameter logic [NUM_BOARDS-1:0]     IS_MEM     = 3'b001,
  parameter logic [NUM_BOARDS-1:0]     ROM_VEC    = 3'b010,
  parameter logic [15:0]               ROM_OFFSET = 16'h0008,
  parameter logic [31:0]               SERIAL     = 32'd1
) (
  input  logic                      CLK,
  input  logic                      RESET_n,
  input  logic [23:1]               ADDR,
  input  logic                      AS_n,
  input  logic                      RW,
  input  logic [3:0]                DIN,
  input  logic                      z2_data,
  input  logic [NUM_BOARDS-1:0]     board_en,
  input  logic                      cfgin_n,
  output logic                      cfgout_n,
  output logic                      autoconfig_cycle,
  output logic [3:0]                DOUT,
  output logic                      dtack,
  output logic [NUM_BOARDS-1:0]     configured,
  output logic [8*NUM_BOARDS-1:0]   base_addr,
  output logic [NUM_BOARDS-1:0]     board_hit
);

  logic                             as_d1_r, as_d2_r, as_d3_r;
  logic                             as_end_s;
  logic                             cfgin_r, done_q_r;
  chain_state_t                     state_r, state_s;
  logic [1:0]                       cur_r, cur_s;
  logic [3:0]                       en_r, en_pad_s;
  logic                             first_found_s, next_found_s;
  logic [1:0]                       first_idx_s, next_idx_s;
  logic [3:0]                       lo_pend_r;
  logic [NUM_BOARDS-1:0]            cfg_r;
  logic [NUM_BOARDS-1:0][7:0]       base_r;
  logic [NUM_BOARDS-1:0]            hit_s;
  logic                             dtack_r;
  logic [3:0]                       dout_r;
  logic                             access_s, wr_base_s, wr_lo_s, wr_shut_s;
  logic [7:0]                       index_s;
  logic                             sel_mem_s, sel_rom_s;
  logic [2:0]                       sel_size_s;
  logic [7:0]                       sel_prod_s;
  logic [3:0]                       rom_nib_s;
  logic                             ac_cycle_s;
  logic                             unused_addr_s;

  assign unused_addr_s = ^ADDR[15:9];
  assign index_s       = ADDR[8:1];
  assign as_end_s      = as_d2_r & ~as_d3_r;
  assign ac_cycle_s    = (ADDR[23:16] == 8'hE8) && cfgin_r && !done_q_r;
  assign access_s      = z2_data && ac_cycle_s && !dtack_r;
  assign wr_lo_s       = access_s && !RW && (index_s == REG_BASE_LO);
  assign wr_base_s     = access_s && !RW && (index_s == REG_BASE_HI) && (state_r == CH_ACTIVE);
  assign wr_shut_s     = access_s && !RW && (index_s == REG_SHUTUP) && (state_r == CH_ACTIVE);

  // Lowest enabled board at start-up and next enabled board above cur.
  always_comb begin
    en_pad_s = 4'b0000;
    en_pad_s[NUM_BOARDS-1:0] = board_en;
    first_idx_s = 2'd0;
    next_idx_s  = 2'd0;
    next_found_s = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      first_idx_s  = en_pad_s[i] ? 2'(i) : first_idx_s;
      next_idx_s   = (en_r[i] && (2'(i) > cur_r)) ? 2'(i) : next_idx_s;
      next_found_s = next_found_s | (en_r[i] && (2'(i) > cur_r));
    end
    first_found_s = |en_pad_s;
  end

  // Chain state register; board_en is captured on the first clock after reset.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_r <= CH_INIT;
      cur_r   <= 2'd0;
      en_r    <= 4'b0000;
    end else begin
      state_r <= state_s;
      cur_r   <= cur_s;
      en_r    <= (state_r == CH_INIT) ? en_pad_s : en_r;
    end
  end

  // Chain next state: advance on base write or shut-up.
  always_comb begin
    state_s = state_r;
    cur_s   = cur_r;
    case (state_r)
      CH_INIT: begin
        cur_s   = first_idx_s;
        state_s = first_found_s ? CH_ACTIVE : CH_DONE;
      end
      CH_ACTIVE: begin
        if (wr_base_s || wr_shut_s) begin
          if (next_found_s) begin
            cur_s = next_idx_s;
          end else begin
            state_s = CH_DONE;
          end
        end else begin
          state_s = CH_ACTIVE;
        end
      end
      CH_DONE: state_s = CH_DONE;
      default: state_s = CH_INIT;
    endcase
  end

  // AS_n synchroniser; chain inputs/outputs only move between bus cycles.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      as_d1_r  <= 1'b1;
      as_d2_r  <= 1'b1;
      as_d3_r  <= 1'b1;
      cfgin_r  <= 1'b0;
      done_q_r <= 1'b0;
    end else begin
      as_d1_r <= AS_n;
      as_d2_r <= as_d1_r;
      as_d3_r <= as_d2_r;
      if (as_end_s) begin
        cfgin_r  <= ~cfgin_n;
        done_q_r <= (state_r == CH_DONE);
      end
    end
  end

  // Per-board parameter mux for the current board.
  always_comb begin
    sel_mem_s  = 1'b0;
    sel_rom_s  = 1'b0;
    sel_size_s = 3'd0;
    sel_prod_s = 8'h00;
    for (int i = 0; i < NUM_BOARDS; i++) begin
      sel_mem_s  = (cur_r == 2'(i)) ? IS_MEM[i]         : sel_mem_s;
      sel_rom_s  = (cur_r == 2'(i)) ? ROM_VEC[i]        : sel_rom_s;
      sel_size_s = (cur_r == 2'(i)) ? SIZES[3*i +: 3]   : sel_size_s;
      sel_prod_s = (cur_r == 2'(i)) ? PROD_IDS[8*i +: 8] : sel_prod_s;
    end
  end

  autoconfig_rom u_rom (
    .index      (index_s),
    .is_mem     (sel_mem_s),
    .rom_vec    (sel_rom_s),
    .size       (sel_size_s),
    .prod_id    (sel_prod_s),
    .mfg_id     (MFG_ID),
    .serial     (SERIAL),
    .rom_offset (ROM_OFFSET),
    .nibble     (rom_nib_s)
  );

  // Bus response, low base nibble holding register and per-board config.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      dtack_r   <= 1'b0;
      dout_r    <= 4'h0;
      lo_pend_r <= 4'h0;
      cfg_r     <= '0;
      base_r    <= '0;
    end else begin
      dtack_r <= access_s;
      if (access_s && RW) begin
        dout_r <= rom_nib_s;
      end
      if (wr_lo_s) begin
        lo_pend_r <= DIN;
      end
      for (int i = 0; i < NUM_BOARDS; i++) begin
        if (wr_base_s && (cur_r == 2'(i))) begin
          base_r[i] <= {DIN, lo_pend_r};
          cfg_r[i]  <= 1'b1;
        end
      end
    end
  end

  // Window decode with 8-bit modular distance so addresses below base miss.
  always_comb begin
    logic [7:0] diff_v;
    diff_v = 8'h00;
    hit_s  = '0;
    for (int i = 0; i < NUM_BOARDS; i++) begin
      diff_v   = ADDR[23:16] - base_r[i];
      hit_s[i] = cfg_r[i] && ({1'b0, diff_v} < blocks(SIZES[3*i +: 3]));
    end
  end

  assign autoconfig_cycle = ac_cycle_s;
  assign cfgout_n         = ~done_q_r;
  assign DOUT             = dout_r;
  assign dtack            = dtack_r;
  assign configured       = cfg_r;
  assign base_addr        = base_r;
  assign board_hit        = hit_s;

endmodule

// File: tb/tb_autoconfig_chain.sv
// Scoreboard bench for autoconfig_chain with default board parameters.
module tb_autoconfig_chain;

  logic        CLK = 1'b0;
  logic        RESET_n = 1'b0;
  logic [23:1] ADDR = 23'd0;
  logic        AS_n = 1'b1;
  logic        RW = 1'b1;
  logic [3:0]  DIN = 4'h0;
  logic        z2_data = 1'b0;
  logic [2:0]  board_en = 3'b111;
  logic        cfgin_n = 1'b0;
  logic        cfgout_n, autoconfig_cycle, dtack;
  logic [3:0]  DOUT;
  logic [2:0]  configured, board_hit;
  logic [23:0] base_addr;

  typedef struct {
    logic       chk;
    logic [3:0] data;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic prev_dtack = 1'b0;

  always #5 CLK = ~CLK;

  autoconfig_chain dut (
    .CLK(CLK), .RESET_n(RESET_n), .ADDR(ADDR), .AS_n(AS_n), .RW(RW), .DIN(DIN),
    .z2_data(z2_data), .board_en(board_en), .cfgin_n(cfgin_n), .cfgout_n(cfgout_n),
    .autoconfig_cycle(autoconfig_cycle), .DOUT(DOUT), .dtack(dtack),
    .configured(configured), .base_addr(base_addr), .board_hit(board_hit)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [23:1] ac_addr(input logic [7:0] idx);
    return {8'hE8, 7'b0000000, idx};
  endfunction

  function automatic logic [23:1] hi_addr(input logic [7:0] hi);
    return {hi, 15'd0};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Monitor: every dtack pops one expected response.
  always @(negedge CLK) begin
    exp_t e;
    if (RESET_n) begin
      if (dtack) begin
        check("dtack_gap", {31'd0, prev_dtack}, 32'd0);
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_dtack: got dtack=1, expected none (DOUT=%0h)", DOUT);
        end else begin
          e = exp_q.pop_front();
          if (e.chk) check(e.name, {28'd0, DOUT}, {28'd0, e.data});
        end
      end
      prev_dtack <= dtack;
    end else begin
      prev_dtack <= 1'b0;
    end
  end

  task automatic bus(input string name, input logic [7:0] idx, input logic rw,
                     input logic [3:0] din, input logic ack, input logic [3:0] exp,
                     input logic chk_fall);
    exp_t e;
    ADDR = ac_addr(idx);
    RW   = rw;
    DIN  = din;
    AS_n = 1'b0;
    tick(1);
    if (ack) begin
      e.chk = rw;
      e.data = exp;
      e.name = name;
      exp_q.push_back(e);
    end
    z2_data = 1'b1;
    tick(1);
    z2_data = 1'b0;
    tick(1);
    AS_n = 1'b1;
    RW = 1'b1;
    if (chk_fall) begin
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      check("cfgout_n_hold", {31'd0, cfgout_n}, 32'd1);
      @(posedge CLK);
      @(negedge CLK);
      check("cfgout_n_fall", {31'd0, cfgout_n}, 32'd0);
      tick(2);
    end else begin
      tick(4);
    end
    check({name, "_ack_done"}, exp_q.size(), 32'd0);
  endtask

  task automatic rd(input logic [7:0] idx, input logic [3:0] exp);
    bus($sformatf("read_%02h", idx), idx, 1'b1, 4'h0, 1'b1, exp, 1'b0);
  endtask

  task automatic wr(input logic [7:0] idx, input logic [3:0] din, input logic chk_fall);
    bus($sformatf("write_%02h", idx), idx, 1'b0, din, 1'b1, 4'h0, chk_fall);
  endtask

  task automatic do_reset(input logic [2:0] en, input logic cin);
    RESET_n = 1'b0;
    board_en = en;
    cfgin_n = cin;
    AS_n = 1'b1;
    z2_data = 1'b0;
    RW = 1'b1;
    ADDR = ac_addr(8'h00);
    tick(3);
    RESET_n = 1'b1;
    tick(2);
    AS_n = 1'b0;
    tick(2);
    AS_n = 1'b1;
    tick(4);
  endtask

  task automatic hit(input logic [7:0] hi, input logic [2:0] exp);
    ADDR = hi_addr(hi);
    #1;
    check($sformatf("board_hit_%02h", hi), {29'd0, board_hit}, {29'd0, exp});
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    ADDR = ac_addr(8'h00);
    tick(2);
    check("rst_dout", {28'd0, DOUT}, 32'h0);
    check("rst_dtack", {31'd0, dtack}, 32'd0);
    check("rst_cfgout_n", {31'd0, cfgout_n}, 32'd1);
    check("rst_ac_cycle", {31'd0, autoconfig_cycle}, 32'd0);
    check("rst_configured", {29'd0, configured}, 32'd0);
    check("rst_base_addr", {8'd0, base_addr}, 32'd0);
    check("rst_board_hit", {29'd0, board_hit}, 32'd0);

    // All boards enabled
    do_reset(3'b111, 1'b0);
    check("ac_cycle_active", {31'd0, autoconfig_cycle}, 32'd1);
    rd(8'h00, 4'hE); rd(8'h02, 4'h8); rd(8'h03, 4'hD); rd(8'h01, 4'h0);
    rd(8'h04, 4'h7); rd(8'h05, 4'hF); rd(8'h08, 4'hF); rd(8'h09, 4'h8);
    rd(8'h0A, 4'h2); rd(8'h0B, 4'h4); rd(8'h0C, 4'hF); rd(8'h13, 4'hE);
    rd(8'h14, 4'hF); rd(8'h20, 4'h0); rd(8'h21, 4'h0); rd(8'h30, 4'hF);
    wr(8'h24, 4'h2, 1'b0);
    check("cfg_b0", {29'd0, configured}, 32'h1);
    check("base_b0", {8'd0, base_addr}, 32'h000020);
    hit(8'h9F, 3'b001); hit(8'hA0, 3'b000); hit(8'h20, 3'b001); hit(8'h1F, 3'b000);
    rd(8'h00, 4'hD); rd(8'h03, 4'h9); rd(8'h01, 4'h2); rd(8'h04, 4'hF);
    rd(8'h14, 4'hF); rd(8'h17, 4'h7);
    wr(8'h26, 4'h0, 1'b0);
    check("cfg_after_shutup_b1", {29'd0, configured}, 32'h1);
    rd(8'h00, 4'hC); rd(8'h02, 4'hB); rd(8'h03, 4'h5); rd(8'h01, 4'h1);
    wr(8'h25, 4'h8, 1'b0);
    wr(8'h24, 4'hE, 1'b1);
    check("cfg_b0_b2", {29'd0, configured}, 32'h5);
    check("base_b0_b2", {8'd0, base_addr}, 32'hE80020);
    ADDR = ac_addr(8'h00);
    #1;
    check("ac_cycle_after_done", {31'd0, autoconfig_cycle}, 32'd0);
    bus("read_after_done", 8'h00, 1'b1, 4'h0, 1'b0, 4'h0, 1'b0);
    hit(8'hE8, 3'b100); hit(8'hEA, 3'b000);

    // Board 1 disabled
    do_reset(3'b101, 1'b0);
    rd(8'h00, 4'hE);
    wr(8'h24, 4'h4, 1'b0);
    rd(8'h03, 4'h5); rd(8'h01, 4'h1);
    wr(8'h26, 4'h0, 1'b1);
    check("cfg_skip", {29'd0, configured}, 32'h1);
    check("base_skip", {8'd0, base_addr}, 32'h000040);

    // Shut-up on every board
    do_reset(3'b111, 1'b0);
    wr(8'h26, 4'h0, 1'b0);
    wr(8'h26, 4'h0, 1'b0);
    wr(8'h26, 4'h0, 1'b1);
    check("cfg_all_shutup", {29'd0, configured}, 32'h0);
    ADDR = ac_addr(8'h00);
    #1;
    check("ac_cycle_all_shutup", {31'd0, autoconfig_cycle}, 32'd0);

    // Chain input not asserted
    do_reset(3'b111, 1'b1);
    check("ac_cycle_cfgin_high", {31'd0, autoconfig_cycle}, 32'd0);
    bus("read_cfgin_high", 8'h00, 1'b1, 4'h0, 1'b0, 4'h0, 1'b0);
    check("dout_cfgin_high", {28'd0, DOUT}, 32'h0);
    check("cfgout_cfgin_high", {31'd0, cfgout_n}, 32'd1);

    // Reset in the middle of the sequence
    do_reset(3'b111, 1'b0);
    wr(8'h24, 4'h3, 1'b0);
    rd(8'h00, 4'hD);
    RESET_n = 1'b0;
    #2;
    check("midrst_cfg", {29'd0, configured}, 32'h0);
    check("midrst_base", {8'd0, base_addr}, 32'h0);
    check("midrst_cfgout_n", {31'd0, cfgout_n}, 32'd1);
    check("midrst_dout", {28'd0, DOUT}, 32'h0);
    do_reset(3'b111, 1'b0);
    rd(8'h00, 4'hE);

    // Board_en re-sampled at release
    do_reset(3'b110, 1'b0);
    rd(8'h00, 4'hD);
    do_reset(3'b000, 1'b0);
    check("none_enabled_cfgout_n", {31'd0, cfgout_n}, 32'd0);
    check("none_enabled_ac_cycle", {31'd0, autoconfig_cycle}, 32'd0);

    tick(4);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
